// File: rtl/bus_source_arbiter_if.sv
// Bus-source arbitration bundle: request/hold in, registered select/grant/status out.
// Latency: none (wires only).
// Backpressure: none; requests are level signals resampled every cycle.
interface bus_source_arbiter_if #(
  parameter int N_SRC = 32,
  parameter int SEL_W = 5
) ();
  logic [N_SRC-1:0] req;
  logic             hold;
  logic [SEL_W-1:0] sel;
  logic [N_SRC-1:0] grant;
  logic             valid;
  logic             multi;

  // Control unit side: raises requests, reads back the granted source.
  modport master (output req, hold, input sel, grant, valid, multi);
  // Arbiter side.
  modport slave  (input req, hold, output sel, grant, valid, multi);
endinterface

// File: rtl/bus_source_arbiter.sv
// Registered bus-source arbiter: fixed priority (highest index) or round-robin, with grant-hold.
// Latency: 1 cycle from req/hold sampled at an edge to sel/grant/valid/multi; no comb path req->out.
// Backpressure: none; hold keeps the current grant while its request stays high.
// Optional macro BUS_ARB_CONFLICT_CNT_EN adds a saturating 16-bit conflict counter output.
module bus_source_arbiter #(
  parameter int N_SRC   = 32,
  parameter int SEL_W   = 5,
  parameter int RR_MODE = 0
) (
  input  logic                  clk,
  input  logic                  clr,
  bus_source_arbiter_if.slave   bus
`ifdef BUS_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]           conflict_cnt
`endif
);

  // Reject configurations whose select cannot encode every source.
  generate
    if (SEL_W < $clog2(N_SRC)) begin : g_selw_chk
      $error("bus_source_arbiter: SEL_W=%0d too narrow for N_SRC=%0d", SEL_W, N_SRC);
    end
    if (N_SRC < 2 || N_SRC > 64) begin : g_nsrc_chk
      $error("bus_source_arbiter: N_SRC=%0d outside 2..64", N_SRC);
    end
  endgenerate

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [N_SRC-1:0] grant_q, grant_d;
  logic             valid_q, valid_d;
  logic             multi_q, multi_d;
  logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0] win;
  logic             req_any;
  logic             req_multi;

  assign req_any   = |bus.req;
  // More than one bit set iff clearing the lowest set bit leaves something behind.
  assign req_multi = |(bus.req & (bus.req - N_SRC'(1)));

  // Winner of a fresh arbitration over the current request vector.
  always_comb begin : p_winner
    int idx;
    idx = 0;
    win = '0;
    if (RR_MODE != 0) begin
      // Downward scan from rr_ptr-1 with wrap; iterate the scan backwards so the
      // last assignment made is the first hit in scan order.
      for (int k = N_SRC; k >= 1; k--) begin
        idx = (int'(rr_ptr_q) + N_SRC - k) % N_SRC;
        if (bus.req[idx]) win = SEL_W'(idx);
      end
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (bus.req[i]) win = SEL_W'(i);
      end
    end
  end

  // Next-state and registered-output decode for the IDLE/GRANT machine.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    grant_d  = grant_q;
    valid_d  = valid_q;
    rr_ptr_d = rr_ptr_q;
    multi_d  = req_multi;
    case (state_q)
      IDLE: begin
        // hold has no meaning without a current grant.
        if (req_any) begin
          state_d  = GRANT;
          sel_d    = win;
          grant_d  = N_SRC'(1) << win;
          valid_d  = 1'b1;
          rr_ptr_d = win;
        end else begin
          sel_d   = '0;
          grant_d = '0;
          valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (bus.hold && bus.req[sel_q]) begin
          // Keep the bus with the current owner; pointer is frozen too.
          state_d = GRANT;
        end else if (!req_any) begin
          state_d = IDLE;
          sel_d   = '0;
          grant_d = '0;
          valid_d = 1'b0;
        end else begin
          sel_d    = win;
          grant_d  = N_SRC'(1) << win;
          valid_d  = 1'b1;
          rr_ptr_d = win;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = '0;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  // State, output and round-robin pointer registers; clr clears everything at once.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      grant_q  <= '0;
      valid_q  <= 1'b0;
      multi_q  <= 1'b0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      grant_q  <= grant_d;
      valid_q  <= valid_d;
      multi_q  <= multi_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.grant = grant_q;
  assign bus.valid = valid_q;
  assign bus.multi = multi_q;

`ifdef BUS_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt_q;

  // Count cycles with competing requests, sticking at all-ones.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      conflict_cnt_q <= '0;
    end else if (req_multi && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_q <= conflict_cnt_q + 16'd1;
    end
  end

  assign conflict_cnt = conflict_cnt_q;
`endif

endmodule
